// File: rtl/i2c_temp_poll_ctrl.sv
// i2c_temp_poll_ctrl: periodic TMP102-class temperature poller driving a byte-level I2C command engine.
// Define TEMP_ALERT_EN to build the signed over-temperature alert flag; otherwise alert is tied low.
module i2c_temp_poll_ctrl #(
    parameter int unsigned POLL_CYCLES = 50_000_000,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
    parameter logic [7:0]  PTR_REG     = 8'h00,
    parameter logic [11:0] TEMP_HI     = 12'h320
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        enable,
    input  logic        force_start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic [11:0] temp,
    output logic        temp_valid,
    output logic        err,
    output logic        busy,
    output logic        alert
);
    localparam int unsigned   TW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_RSTART    = 3'd1;
    localparam logic [2:0] OP_WRITE     = 3'd2;
    localparam logic [2:0] OP_READ_ACK  = 3'd3;
    localparam logic [2:0] OP_READ_NACK = 3'd4;
    localparam logic [2:0] OP_STOP      = 3'd5;

    typedef enum logic [3:0] {
        IDLE, ST_START, WR_ADDR_W, WR_PTR, ST_RSTART, WR_ADDR_R, RD_MSB, RD_LSB, ST_STOP, DONE
    } state_t;

    function automatic logic [2:0] op_of(input state_t s);
        case (s)
            ST_START:                     op_of = OP_START;
            ST_RSTART:                    op_of = OP_RSTART;
            WR_ADDR_W, WR_PTR, WR_ADDR_R: op_of = OP_WRITE;
            RD_MSB:                       op_of = OP_READ_ACK;
            RD_LSB:                       op_of = OP_READ_NACK;
            default:                      op_of = OP_STOP;
        endcase
    endfunction

    function automatic logic [7:0] data_of(input state_t s);
        case (s)
            WR_ADDR_W: data_of = {SLAVE_ADDR, 1'b0};
            WR_PTR:    data_of = PTR_REG;
            WR_ADDR_R: data_of = {SLAVE_ADDR, 1'b1};
            default:   data_of = 8'h00;
        endcase
    endfunction

    // A NACKed write diverts straight to STOP so the bus is always released.
    function automatic state_t next_of(input state_t s, input logic nack);
        case (s)
            ST_START:  next_of = WR_ADDR_W;
            WR_ADDR_W: next_of = nack ? ST_STOP : WR_PTR;
            WR_PTR:    next_of = nack ? ST_STOP : ST_RSTART;
            ST_RSTART: next_of = WR_ADDR_R;
            WR_ADDR_R: next_of = nack ? ST_STOP : RD_MSB;
            RD_MSB:    next_of = RD_LSB;
            RD_LSB:    next_of = ST_STOP;
            ST_STOP:   next_of = DONE;
            default:   next_of = IDLE;
        endcase
    endfunction

    state_t        state_r, state_nxt, adv_s;
    logic          wait_r, wait_nxt, nack_r, nack_nxt, start_s, write_nack_s;
    logic          cmd_valid_r, cmd_valid_nxt, temp_valid_r, temp_valid_nxt;
    logic          err_r, err_nxt, busy_r;
    logic [2:0]    cmd_op_r, cmd_op_nxt;
    logic [7:0]    cmd_data_r, cmd_data_nxt, msb_r, msb_nxt;
    logic [3:0]    lsb_r, lsb_nxt;
    logic [11:0]   temp_r, temp_nxt;
    logic [TW-1:0] timer_r, timer_nxt;

    // Next-state, command and capture logic; wait_r marks a command accepted but not yet answered.
    always_comb begin
        state_nxt      = state_r;
        wait_nxt       = wait_r;
        nack_nxt       = nack_r;
        cmd_valid_nxt  = cmd_valid_r;
        cmd_op_nxt     = cmd_op_r;
        cmd_data_nxt   = cmd_data_r;
        msb_nxt        = msb_r;
        lsb_nxt        = lsb_r;
        temp_nxt       = temp_r;
        temp_valid_nxt = 1'b0;
        err_nxt        = 1'b0;
        adv_s          = IDLE;
        write_nack_s   = 1'b0;
        start_s        = (state_r == IDLE) && (force_start || (enable && (timer_r == '0)));

        // Timer keeps running through a transaction so starts stay POLL_CYCLES apart.
        if (start_s) begin
            timer_nxt = RELOAD;
        end else if (!enable) begin
            timer_nxt = RELOAD;
        end else if (timer_r != '0) begin
            timer_nxt = timer_r - TW'(1);
        end else begin
            timer_nxt = timer_r;
        end

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt     = ST_START;
                    nack_nxt      = 1'b0;
                    cmd_valid_nxt = 1'b1;
                    cmd_op_nxt    = OP_START;
                    cmd_data_nxt  = 8'h00;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ST_START, WR_ADDR_W, WR_PTR, ST_RSTART, WR_ADDR_R, RD_MSB, RD_LSB, ST_STOP: begin
                if (!wait_r) begin
                    if (cmd_valid_r && cmd_ready) begin
                        cmd_valid_nxt = 1'b0;
                        wait_nxt      = 1'b1;
                    end else begin
                        cmd_valid_nxt = cmd_valid_r;
                    end
                end else if (rsp_valid) begin
                    write_nack_s = rsp_nack && (cmd_op_r == OP_WRITE);
                    adv_s        = next_of(state_r, write_nack_s);
                    wait_nxt     = 1'b0;
                    state_nxt    = adv_s;
                    nack_nxt     = nack_r | write_nack_s;
                    if (state_r == RD_MSB) begin
                        msb_nxt = rsp_data;
                    end else begin
                        msb_nxt = msb_r;
                    end
                    if (state_r == RD_LSB) begin
                        lsb_nxt = rsp_data[7:4];
                    end else begin
                        lsb_nxt = lsb_r;
                    end
                    if (adv_s == DONE) begin
                        temp_valid_nxt = ~nack_r;
                        err_nxt        = nack_r;
                        temp_nxt       = nack_r ? temp_r : {msb_r, lsb_r};
                    end else begin
                        cmd_valid_nxt = 1'b1;
                        cmd_op_nxt    = op_of(adv_s);
                        cmd_data_nxt  = data_of(adv_s);
                    end
                end else begin
                    wait_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                wait_nxt      = 1'b0;
                cmd_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r      <= IDLE;
            wait_r       <= 1'b0;
            nack_r       <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_op_r     <= 3'd0;
            cmd_data_r   <= 8'h00;
            msb_r        <= 8'h00;
            lsb_r        <= 4'h0;
            temp_r       <= 12'h000;
            temp_valid_r <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            timer_r      <= RELOAD;
        end else begin
            state_r      <= state_nxt;
            wait_r       <= wait_nxt;
            nack_r       <= nack_nxt;
            cmd_valid_r  <= cmd_valid_nxt;
            cmd_op_r     <= cmd_op_nxt;
            cmd_data_r   <= cmd_data_nxt;
            msb_r        <= msb_nxt;
            lsb_r        <= lsb_nxt;
            temp_r       <= temp_nxt;
            temp_valid_r <= temp_valid_nxt;
            err_r        <= err_nxt;
            busy_r       <= (state_nxt != IDLE);
            timer_r      <= timer_nxt;
        end
    end

    assign cmd_valid  = cmd_valid_r;
    assign cmd_op     = cmd_op_r;
    assign cmd_data   = cmd_data_r;
    assign temp       = temp_r;
    assign temp_valid = temp_valid_r;
    assign err        = err_r;
    assign busy       = busy_r;

`ifdef TEMP_ALERT_EN
    logic alert_r;

    // Alert re-evaluated only when a fresh good reading lands.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            alert_r <= 1'b0;
        end else if (temp_valid_nxt) begin
            alert_r <= ($signed(temp_nxt) > $signed(TEMP_HI));
        end else begin
            alert_r <= alert_r;
        end
    end

    assign alert = alert_r;
`else
    assign alert = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_temp_poll_ctrl.sv
// Self-checking bench for i2c_temp_poll_ctrl: behavioural byte engine, command/result scoreboards
// and a vector table, plus hand sequences for timer, enable, force and reset corners.
module tb_i2c_temp_poll_ctrl;
    localparam int POLL = 64;
`ifdef TEMP_ALERT_EN
    localparam logic ALERT_ON = 1'b1;
`else
    localparam logic ALERT_ON = 1'b0;
`endif

    logic        PCLK, PRESETN, enable, force_start;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_nack;
    logic        temp_valid, err, busy, alert;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data, rsp_data;
    logic [11:0] temp;

    typedef struct { logic [2:0] op; logic [7:0] data; } cmd_t;
    typedef struct { logic is_err; logic [11:0] temp; logic alert; } res_t;
    typedef struct {
        logic [7:0] msb; logic [7:0] lsb; int nack_idx; int ready_dly;
        logic [11:0] exp_temp; logic exp_alert;
    } vec_t;

    cmd_t exp_q[$];
    res_t res_q[$];
    vec_t vecs [8];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] eng_msb, eng_lsb;
    int         eng_nack_idx, eng_ready_delay, eng_rsp_lat;
    logic       eng_spurious;
    logic       outstanding, seen_cmd, seen_rd_ack;
    int         rsp_cnt, hold_cnt, wr_idx, start_cnt, last_start_cyc;
    logic [2:0] acc_op, held_op;
    logic [7:0] held_data;

    i2c_temp_poll_ctrl #(.POLL_CYCLES(POLL)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .enable(enable), .force_start(force_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .temp(temp), .temp_valid(temp_valid), .err(err), .busy(busy), .alert(alert)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] data);
        cmd_t c;
        c.op = op;
        c.data = data;
        exp_q.push_back(c);
    endtask

    // Expected command order and final result for one transaction.
    task automatic push_txn(input logic [7:0] msb, input logic [7:0] lsb, input int nack_idx,
                            input logic [11:0] exp_temp, input logic exp_alert);
        res_t r;
        eng_msb = msb;
        eng_lsb = lsb;
        eng_nack_idx = nack_idx;
        push_cmd(3'd0, 8'h00);
        push_cmd(3'd2, 8'h90);
        if (nack_idx == 1) begin
            push_cmd(3'd5, 8'h00);
        end else begin
            push_cmd(3'd2, 8'h00);
            if (nack_idx == 2) begin
                push_cmd(3'd5, 8'h00);
            end else begin
                push_cmd(3'd1, 8'h00);
                push_cmd(3'd2, 8'h91);
                if (nack_idx != 3) begin
                    push_cmd(3'd3, 8'h00);
                    push_cmd(3'd4, 8'h00);
                end
                push_cmd(3'd5, 8'h00);
            end
        end
        r.is_err = (nack_idx != 0);
        r.temp   = exp_temp;
        r.alert  = exp_alert & ALERT_ON;
        res_q.push_back(r);
    endtask

    task automatic pulse_force();
        force_start = 1'b1;
        @(negedge PCLK);
        force_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge PCLK);
        while ((busy || exp_q.size() != 0 || res_q.size() != 0) && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        check({name, "_done"}, 32'(n < 3000), 32'd1);
    endtask

    // Behavioural byte engine: configurable ready stall, response latency, NACK injection.
    initial begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
        outstanding = 1'b0; seen_cmd = 1'b0; seen_rd_ack = 1'b0;
        rsp_cnt = 0; hold_cnt = 0; wr_idx = 0; start_cnt = 0; last_start_cyc = 0;
        acc_op = 3'd0; held_op = 3'd0; held_data = 8'h00;
        forever begin
            @(negedge PCLK);
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00; cmd_ready = 1'b0;
            if (!PRESETN) begin
                outstanding = 1'b0;
                seen_cmd = 1'b0;
            end else if (outstanding) begin
                rsp_cnt--;
                if (rsp_cnt <= 0) begin
                    outstanding = 1'b0;
                    rsp_valid = 1'b1;
                    rsp_data = (acc_op == 3'd3) ? eng_msb : ((acc_op == 3'd4) ? eng_lsb : 8'h00);
                    rsp_nack = (acc_op == 3'd2) && (wr_idx == eng_nack_idx);
                end
            end else if (cmd_valid) begin
                if (!seen_cmd) begin
                    seen_cmd = 1'b1; held_op = cmd_op; held_data = cmd_data; hold_cnt = 0;
                end else begin
                    check("hold_op", 32'(cmd_op), 32'(held_op));
                    check("hold_data", 32'(cmd_data), 32'(held_data));
                end
                if (hold_cnt < eng_ready_delay) begin
                    hold_cnt++;
                    if (eng_spurious && hold_cnt == 2) begin
                        rsp_valid = 1'b1; rsp_nack = 1'b1; rsp_data = 8'hFF;
                    end
                end else begin
                    cmd_ready = 1'b1; outstanding = 1'b1; rsp_cnt = eng_rsp_lat;
                    seen_cmd = 1'b0; acc_op = cmd_op;
                    if (cmd_op == 3'd0) begin
                        wr_idx = 0; start_cnt++; last_start_cyc = cyc;
                    end
                    if (cmd_op == 3'd2) wr_idx++;
                    if (cmd_op == 3'd3) seen_rd_ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("cmd_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        cmd_t c;
                        c = exp_q.pop_front();
                        check("cmd_op", 32'(cmd_op), 32'(c.op));
                        check("cmd_data", 32'(cmd_data), 32'(c.data));
                    end
                end
            end else if (seen_cmd) begin
                check("valid_held", 32'(cmd_valid), 32'd1);
                seen_cmd = 1'b0;
            end
        end
    end

    // Result scoreboard: every temp_valid / err pulse must match the next expected outcome.
    initial begin
        forever begin
            @(negedge PCLK);
            if (temp_valid || err) begin
                if (res_q.size() == 0) begin
                    check("result_unexpected", {30'd0, temp_valid, err}, 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result_kind", {30'd0, temp_valid, err}, r.is_err ? 32'd1 : 32'd2);
                    check("result_temp", 32'(temp), 32'(r.temp));
                    check("result_alert", 32'(alert), 32'(r.alert));
                end
            end
        end
    end

    initial begin
        int rel, s0, s1, n;
        vecs[0] = '{8'h19, 8'h40, 0, 10, 12'h194, 1'b0};
        vecs[1] = '{8'h19, 8'h40, 1, 0,  12'h194, 1'b0};
        vecs[2] = '{8'h32, 8'h10, 0, 0,  12'h321, 1'b1};
        vecs[3] = '{8'hE7, 8'h00, 0, 0,  12'hE70, 1'b0};
        vecs[4] = '{8'h55, 8'h55, 2, 3,  12'hE70, 1'b0};
        vecs[5] = '{8'h7F, 8'hF0, 0, 0,  12'h7FF, 1'b1};
        vecs[6] = '{8'h80, 8'h00, 3, 0,  12'h7FF, 1'b1};
        vecs[7] = '{8'h80, 8'h00, 0, 2,  12'h800, 1'b0};

        PRESETN = 1'b0; enable = 1'b1; force_start = 1'b0;
        eng_msb = 8'h19; eng_lsb = 8'h40; eng_nack_idx = 0;
        eng_ready_delay = 0; eng_rsp_lat = 1; eng_spurious = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_temp", 32'(temp), 32'd0);
        check("rst_pulses", {30'd0, temp_valid, err}, 32'd0);
        check("rst_alert", 32'(alert), 32'd0);

        // Timer-driven polling: first start POLL cycles after reset, then every POLL cycles.
        push_txn(8'h19, 8'h40, 0, 12'h194, 1'b0);
        rel = cyc;
        PRESETN = 1'b1;
        wait_done("t1a");
        check("t1_first_start", 32'(last_start_cyc - rel), 32'(POLL));
        check("t1_temp", 32'(temp), 32'h194);
        s1 = last_start_cyc;
        push_txn(8'h19, 8'h40, 0, 12'h194, 1'b0);
        wait_done("t1b");
        check("t1_period", 32'(last_start_cyc - s1), 32'(POLL));

        // enable dropped mid-transaction: it completes, then no further starts.
        push_txn(8'h19, 8'h40, 0, 12'h194, 1'b0);
        n = 0;
        while (!busy && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        enable = 1'b0;
        wait_done("t4");
        s0 = start_cnt;
        repeat (3 * POLL) @(negedge PCLK);
        check("t4_no_start", 32'(start_cnt - s0), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // Vector table: force-started transactions; a second force while busy must be ignored.
        for (int i = 0; i < 8; i++) begin
            eng_ready_delay = vecs[i].ready_dly;
            eng_spurious = (vecs[i].ready_dly >= 3);
            s0 = start_cnt;
            push_txn(vecs[i].msb, vecs[i].lsb, vecs[i].nack_idx, vecs[i].exp_temp, vecs[i].exp_alert);
            pulse_force();
            repeat (4) @(negedge PCLK);
            pulse_force();
            wait_done("vec");
            check("vec_starts", 32'(start_cnt - s0), 32'd1);
            check("vec_temp", 32'(temp), 32'(vecs[i].exp_temp));
        end
        eng_ready_delay = 0;
        eng_spurious = 1'b0;

        // force on the same edge the timer expires: exactly one transaction.
        push_txn(8'h19, 8'h40, 0, 12'h194, 1'b0);
        s0 = start_cnt;
        rel = cyc;
        enable = 1'b1;
        repeat (POLL - 1) @(negedge PCLK);
        force_start = 1'b1;
        @(negedge PCLK);
        force_start = 1'b0;
        enable = 1'b0;
        wait_done("coin");
        repeat (100) @(negedge PCLK);
        check("coin_starts", 32'(start_cnt - s0), 32'd1);
        check("coin_when", 32'(last_start_cyc - rel), 32'(POLL));

        // Async reset while waiting on READ_ACK, then a clean restart.
        eng_rsp_lat = 20;
        seen_rd_ack = 1'b0;
        push_txn(8'h19, 8'h40, 0, 12'h194, 1'b0);
        pulse_force();
        n = 0;
        while (!seen_rd_ack && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        check("t5_reached_read", 32'(seen_rd_ack), 32'd1);
        repeat (5) @(negedge PCLK);
        PRESETN = 1'b0;
        #1;
        check("t5_cmd_valid", 32'(cmd_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_temp", 32'(temp), 32'd0);
        check("t5_alert", 32'(alert), 32'd0);
        exp_q.delete();
        res_q.delete();
        eng_rsp_lat = 1;
        repeat (2) @(negedge PCLK);
        enable = 1'b1;
        push_txn(8'h19, 8'h40, 0, 12'h194, 1'b0);
        rel = cyc;
        PRESETN = 1'b1;
        wait_done("t5");
        check("t5_first_start", 32'(last_start_cyc - rel), 32'(POLL));
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
